// File: rtl/bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bird_motion_ctrl
// Purpose  : Bird controller for the flappy-bird datapath. Combines the bird
//            mode FSM (start / raising / falling / stop) with a vertical
//            position and velocity integrator. Every accepted physics tick
//            runs an erase -> update -> draw handshake with the VGA plotter.
// Ports    : clk        - system clock, all logic on posedge
//            reset      - synchronous, active-high
//            frame_tick - one-cycle physics pulse from the frame timer
//            press_key  - flap button
//            touched    - collision flag from the pipe unit
//            draw_done  - plotter finished the current request
//            draw_req   - plot request (DEL and DRAW states)
//            draw_erase - 1 = background colour, 0 = bird colour
//            bird_y     - current bird row
//            game_over  - high while in STOP
//            frame_miss - one-cycle pulse when a tick arrived mid-handshake
//            state_out  - current state code for the top-level mux
// Options  : BIRD_KEY_EDGE_EN - when defined, a flap is the rising edge of
//            press_key; otherwise the key level flaps every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bird_motion_ctrl #(
  parameter int Y_W     = 7,
  parameter int V_W     = 5,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 112,
  parameter int Y_START = 60,
  parameter int FLAP_V  = 4,
  parameter int GRAV    = 1,
  parameter int VMAX    = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_tick,
  input  logic           press_key,
  input  logic           touched,
  input  logic           draw_done,
  output logic           draw_req,
  output logic           draw_erase,
  output logic [Y_W-1:0] bird_y,
  output logic           game_over,
  output logic           frame_miss,
  output logic [3:0]     state_out
);

  typedef enum logic [3:0] {
    S_START   = 4'b0000,
    S_RAISING = 4'b0001,
    S_FALLING = 4'b0010,
    S_STOP    = 4'b0011,
    S_DRAW    = 4'b0100,
    S_INIT    = 4'b0110,
    S_UPDATE  = 4'b1110,
    S_DEL     = 4'b1111
  } state_t;

  // Constants pre-sized to the arithmetic widths they are compared against.
  localparam logic signed [Y_W:0]   Y_MIN_X   = (Y_W+1)'(Y_MIN);
  localparam logic signed [Y_W:0]   Y_MAX_X   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]        Y_START_X = Y_W'(Y_START);
  localparam logic signed [V_W:0]   VMAX_X    = (V_W+1)'(VMAX);
  localparam logic signed [V_W:0]   GRAV_X    = (V_W+1)'(GRAV);
  localparam logic signed [V_W-1:0] FLAP_NEG  = V_W'(-FLAP_V);

  state_t                state;
  state_t                state_nxt;
  state_t                after_draw;
  state_t                mode_nxt;
  logic signed [V_W-1:0] vel;
  logic                  flap_pend;
  logic                  hit;
  logic                  flap;

  // --------------------------------------------------------------------------
  // Flap event
  // --------------------------------------------------------------------------
`ifdef BIRD_KEY_EDGE_EN
  logic key_prev;

  // Resetting the history to 1 keeps a key held through reset from flapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev <= 1'b1;
    end else begin
      key_prev <= press_key;
    end
  end

  assign flap = press_key & ~key_prev;
`else
  assign flap = press_key;
`endif

  // --------------------------------------------------------------------------
  // Physics step evaluated during UPDATE
  // --------------------------------------------------------------------------
  logic signed [V_W:0]   vel_inc;
  logic signed [V_W-1:0] vel_step;
  logic signed [Y_W:0]   y_sum;
  logic [Y_W-1:0]        y_next;
  logic signed [V_W-1:0] vel_next;

  // One extra bit of headroom so vel+GRAV cannot wrap before the VMAX cap.
  assign vel_inc  = $signed({vel[V_W-1], vel}) + GRAV_X;
  assign vel_step = flap_pend          ? FLAP_NEG :
                    (vel_inc > VMAX_X) ? VMAX_X[V_W-1:0] : vel_inc[V_W-1:0];

  // y is zero-extended to a signed Y_W+1 value so an upward step past the
  // ceiling shows up as negative instead of wrapping to a large row.
  assign y_sum = $signed({1'b0, bird_y}) +
                 $signed({{(Y_W+1-V_W){vel_step[V_W-1]}}, vel_step});

  always_comb begin
    y_next   = y_sum[Y_W-1:0];
    vel_next = vel_step;
    if (y_sum < Y_MIN_X) begin
      // Hitting the ceiling kills the upward speed.
      y_next   = Y_MIN_X[Y_W-1:0];
      vel_next = '0;
    end else if (y_sum > Y_MAX_X) begin
      y_next   = Y_MAX_X[Y_W-1:0];
    end
  end

  always_comb begin
    if (hit || (y_next == Y_MAX_X[Y_W-1:0])) begin
      mode_nxt = S_STOP;
    end else if (vel_next[V_W-1]) begin
      mode_nxt = S_RAISING;
    end else begin
      mode_nxt = S_FALLING;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:    state_nxt = S_DRAW;
      // A flap arriving together with the tick counts for that tick.
      S_START:   if (frame_tick && (flap_pend || flap)) state_nxt = S_DEL;
      S_RAISING: if (frame_tick) state_nxt = S_DEL;
      S_FALLING: if (frame_tick) state_nxt = S_DEL;
      S_STOP:    if (flap) state_nxt = S_DEL;
      S_DEL:     if (draw_done) state_nxt = S_UPDATE;
      S_UPDATE:  state_nxt = S_DRAW;
      S_DRAW:    if (draw_done) state_nxt = after_draw;
      default:   state_nxt = S_INIT;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_INIT;
      after_draw <= S_START;
      bird_y     <= Y_START_X;
      vel        <= '0;
      flap_pend  <= 1'b0;
      hit        <= 1'b0;
      draw_req   <= 1'b0;
      draw_erase <= 1'b0;
      game_over  <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Outputs follow the state being entered so they line up with it.
      draw_req   <= (state_nxt == S_DEL) || (state_nxt == S_DRAW);
      draw_erase <= (state_nxt == S_DEL);
      game_over  <= (state_nxt == S_STOP);
      frame_miss <= frame_tick &&
                    ((state == S_DEL) || (state == S_UPDATE) || (state == S_DRAW));

      if (state == S_UPDATE) begin
        // The pending flap is consumed here; a fresh flap this cycle survives.
        flap_pend <= flap;
        if (after_draw == S_STOP) begin
          bird_y     <= Y_START_X;
          vel        <= '0;
          hit        <= touched;
          after_draw <= S_START;
        end else begin
          bird_y     <= y_next;
          vel        <= vel_next;
          hit        <= hit | touched;
          after_draw <= mode_nxt;
        end
      end else begin
        flap_pend <= flap_pend | flap;
        hit       <= hit | touched;
      end
    end
  end

  assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_bird_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bird_motion_ctrl
// Purpose  : Scoreboard bench for bird_motion_ctrl. Stimulus updates a frame-
//            level physics model and queues the expected erase/draw requests;
//            a monitor pops and compares them as the DUT issues requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bird_motion_ctrl;

  localparam int Y_MAX   = 112;
  localparam int Y_START = 60;
  localparam int FLAP_V  = 4;
  localparam int VMAX    = 6;
  // Mode codes match the DUT's state_out values for the four bird modes.
  localparam int M_START = 0, M_RAISING = 1, M_FALLING = 2, M_STOP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       press_key;
  logic       touched;
  logic       draw_done;
  logic       draw_req;
  logic       draw_erase;
  logic [6:0] bird_y;
  logic       game_over;
  logic       frame_miss;
  logic [3:0] state_out;

  bird_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .press_key  (press_key),
    .touched    (touched),
    .draw_done  (draw_done),
    .draw_req   (draw_req),
    .draw_erase (draw_erase),
    .bird_y     (bird_y),
    .game_over  (game_over),
    .frame_miss (frame_miss),
    .state_out  (state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit erase;
    int y;
    int mode;
  } exp_t;

  exp_t sb[$];
  int   total    = 0;
  int   bad      = 0;
  int   seq_done = 0;
  bit   stall    = 1'b0;

  // Frame-level reference model
  int m_y, m_vel, m_mode, m_hit, m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic void model_update();
    if (m_mode == M_STOP) begin
      m_y   = Y_START;
      m_vel = 0;
      m_hit = 0;
      m_mode = M_START;
    end else begin
      int s;
      m_vel = m_pend ? -FLAP_V : ((m_vel + 1 > VMAX) ? VMAX : m_vel + 1);
      s = m_y + m_vel;
      if (s < 0) begin
        s = 0;
        m_vel = 0;
      end
      if (s > Y_MAX) s = Y_MAX;
      m_y = s;
      if (m_hit != 0 || m_y == Y_MAX) m_mode = M_STOP;
      else if (m_vel < 0)             m_mode = M_RAISING;
      else                            m_mode = M_FALLING;
    end
    m_pend = 0;
  endfunction

  // Plotter: acknowledges requests after a random delay unless stalled.
  initial begin
    draw_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      draw_done = draw_req && !stall && ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: compares each new request, then the mode reached after DRAW.
  initial begin
    bit   prev_req = 1'b0;
    bit   mode_pend = 1'b0;
    int   exp_mode = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req  = 1'b0;
        mode_pend = 1'b0;
      end else begin
        if (mode_pend) begin
          check("mode", state_out, exp_mode);
          check("game_over", game_over, (exp_mode == M_STOP) ? 1 : 0);
          mode_pend = 1'b0;
          seq_done++;
        end
        if (draw_req && !prev_req) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_req: got erase=%0d y=%0d want no request",
                     draw_erase, bird_y);
          end else begin
            e = sb.pop_front();
            check(e.erase ? "erase_flag" : "draw_flag", draw_erase, e.erase);
            check(e.erase ? "erase_y" : "draw_y", bird_y, e.y);
            if (!e.erase) exp_mode = e.mode;
          end
        end
        if (draw_req && !draw_erase && draw_done) mode_pend = 1'b1;
        prev_req = draw_req;
      end
    end
  end

  task automatic wait_seq(input int target);
    int n = 0;
    while (seq_done < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (seq_done < target) begin
      total++;
      bad++;
      $display("FAIL seq_timeout: got %0d sequences want %0d", seq_done, target);
    end
  endtask

  // Queue the erase/draw pair for an accepted frame and advance the model.
  function automatic void push_seq();
    exp_t e;
    e.erase = 1'b1; e.y = m_y; e.mode = 0;
    sb.push_back(e);
    model_update();
    e.erase = 1'b0; e.y = m_y; e.mode = m_mode;
    sb.push_back(e);
  endfunction

  function automatic bit accepts(input bit f, input bit tk);
    if (m_mode == M_STOP)  return f;
    if (m_mode == M_START) return tk && (m_pend != 0);
    return tk;
  endfunction

  task automatic do_frame(input bit f, input bit t, input bit tk);
    bit trig;
    int target;
    @(negedge clk);
    press_key  = f;
    touched    = t;
    frame_tick = tk;
    if (f) m_pend = 1;
    if (t) m_hit = 1;
    trig   = accepts(f, tk);
    target = seq_done + 1;
    if (trig) push_seq();
    @(negedge clk);
    press_key  = 1'b0;
    touched    = 1'b0;
    frame_tick = 1'b0;
    if (trig) wait_seq(target);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Tick held across the wait cycle and the first DEL cycle: the second
  // cycle of it must be dropped and reported on frame_miss.
  task automatic miss_test();
    int target;
    @(negedge clk);
    stall      = 1'b1;
    frame_tick = 1'b1;
    target     = seq_done + 1;
    push_seq();
    @(negedge clk);
    check("stall_in_del", state_out, 4'b1111);
    @(negedge clk);
    frame_tick = 1'b0;
    check("frame_miss_pulse", frame_miss, 1);
    @(negedge clk);
    check("frame_miss_clear", frame_miss, 0);
    stall = 1'b0;
    wait_seq(target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset      = 1'b1;
    frame_tick = 1'b0;
    press_key  = 1'b0;
    touched    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_out, 4'b0110);
    check("rst_y", bird_y, Y_START);
    check("rst_req", draw_req, 0);
    check("rst_erase", draw_erase, 0);
    check("rst_game_over", game_over, 0);
    check("rst_miss", frame_miss, 0);

    m_y = Y_START; m_vel = 0; m_mode = M_START; m_hit = 0; m_pend = 0;
    begin
      exp_t e;
      e.erase = 1'b0; e.y = Y_START; e.mode = M_START;
      sb.push_back(e);
    end
    reset = 1'b0;
    wait_seq(1);

    // Flap from START, then coast up and over the apex.
    do_frame(1'b1, 1'b0, 1'b1);
    repeat (8) do_frame(1'b0, 1'b0, 1'b1);
    // Repeated flaps drive the bird into the ceiling clamp.
    repeat (20) do_frame(1'b1, 1'b0, 1'b1);

    guard = 0;
    while ((m_mode == M_START || m_mode == M_STOP) && guard < 5) begin
      do_frame(1'b1, 1'b0, 1'b1);
      guard++;
    end
    miss_test();

    // Fall to the ground, then restart with a flap alone.
    guard = 0;
    while (m_mode != M_STOP && guard < 100) begin
      do_frame(1'b0, 1'b0, 1'b1);
      guard++;
    end
    do_frame(1'b0, 1'b0, 1'b1);
    do_frame(1'b1, 1'b0, 1'b0);

    // Collision pulse while waiting in RAISING ends the game on the next tick.
    do_frame(1'b1, 1'b0, 1'b1);
    do_frame(1'b0, 1'b1, 1'b0);
    do_frame(1'b0, 1'b0, 1'b1);
    do_frame(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      do_frame(($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 3) != 0));
    end

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expect: got %0d queued want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Parametrised bird controller for the flappy-bird datapath. Merges the bird mode FSM (start / raising / falling / stop) with a vertical position and velocity integrator. Sequences every frame through an erase-update-draw handshake with the VGA plotter. Takes physics ticks from the frame timer and collisions from the pipe unit, and outputs bird Y, game-over and the state code consumed by the top-level mux.

## Interface
- Y_W, 7: width of bird_y.
- V_W, 5: width of signed velocity (two's complement).
- Y_MIN, 0: ceiling row.
- Y_MAX, 112: ground row; reaching it ends the game.
- Y_START, 60: spawn row.
- FLAP_V, 4: upward speed loaded on a flap.
- GRAV, 1: velocity increment per tick.
- VMAX, 6: terminal fall speed.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle physics pulse.
- press_key  in  1  flap button.
- touched  in  1  collision from pipe unit.
- draw_done  in  1  plotter finished current request.
- draw_req  out  1  plot request.
- draw_erase  out  1  1 = background colour, 0 = bird colour.
- bird_y  out  Y_W  current row.
- game_over  out  1  high in STOP.
- frame_miss  out  1  one-cycle pulse; tick dropped.
- state_out  out  4  current state code.

## Operation
- State encodings:
  - START 0000, RAISING 0001, FALLING 0010, STOP 0011
  - DRAW 0100, INIT 0110, UPDATE 1110, DEL 1111
- Register after_draw holds the mode state entered when DRAW completes.
- Flap event: defined under Configuration. Latched into flap_pend in any state; cleared in UPDATE.
- touched: latched sticky into hit; cleared in UPDATE when leaving STOP.
- INIT: next state is DRAW, with after_draw = START.
- START: on frame_tick with flap_pend, go to DEL. Otherwise stay; bird hovers with no redraw.
- RAISING / FALLING: on frame_tick, go to DEL.
- STOP: on a flap event, go to DEL (restart).
- DEL: draw_req=1, draw_erase=1 at old bird_y. On draw_done, go to UPDATE.
- UPDATE, single cycle, from play states:
  - vel = flap_pend ? -FLAP_V : min(vel+GRAV, VMAX).
  - y' = y + vel, saturated to [Y_MIN, Y_MAX]. At the Y_MIN clamp, vel is forced to 0.
  - after_draw = STOP if hit or y' == Y_MAX; else RAISING if vel < 0; else FALLING.
- UPDATE from STOP: y = Y_START, vel = 0, hit = 0, after_draw = START.
- DRAW: draw_req=1, draw_erase=0 at new bird_y. On draw_done, go to after_draw.
- draw_req and draw_erase are Moore-decoded from state; they are 0 in every other state.
- Arithmetic: y is extended to Y_W+1 signed bits before the add, then saturated. No wrap-around is allowed.

## Timing
- Reset values:
  - state INIT, after_draw START
  - bird_y = Y_START, vel = 0, flap_pend = 0, hit = 0
  - draw_req = 0, draw_erase = 0, game_over = 0, frame_miss = 0
  - state_out = 0110
- draw_done is sampled in DEL and DRAW. A done seen on the entry cycle exits on the next edge, so the minimum is 1 cycle per state.
- Tick-to-mode latency is 3 cycles minimum (DEL, UPDATE, DRAW).
- frame_tick arriving in DEL/UPDATE/DRAW is dropped and frame_miss pulses on the next cycle. There is no queued update.
- Simultaneous events in a play-state wait cycle:
  - tick + flap: the flap applies to this tick.
  - touched + tick: the tick applies and the mode becomes STOP.
- bird_y changes only on the UPDATE→DRAW edge.
- Reset mid-handshake: reset returns the block to INIT immediately. The plotter must tolerate draw_req dropping.

## Configuration
- BIRD_KEY_EDGE_EN defined:
  - flap event = rising edge of press_key, using a registered previous value.
  - The previous value resets to 1, so a key held through reset does not flap.
- BIRD_KEY_EDGE_EN undefined:
  - flap event = press_key level each cycle.
  - A held key re-flaps on every tick.

## Test plan
- Reset, draw_done=1 → INIT, then DRAW (req=1, erase=0, y=60), then START. state_out ends at 0000.
- Flap in START, then tick → DEL, UPDATE, DRAW, RAISING with y=56, vel=-4. Subsequent ticks without key: y=53, 51, 50, 50, then FALLING at vel=0. vel caps at 6.
- From y=2, flap and tick → y=0 (clamped), vel=0, mode FALLING.
- Fall to y=112 → STOP, game_over=1. Flap → erase at 112, y=60, draw, START, game_over=0.
- 1-cycle touched pulse while waiting in RAISING, then tick → after_draw=STOP, state 0011 after DRAW.
- draw_done held 0 in DEL plus frame_tick → frame_miss=1 for one cycle, exactly one UPDATE occurs, bird_y moves once.
